// File: rtl/inst_encoder.sv
// Instruction encoder: packs {OP, FN, RD} into bytes, buffers them in a small FIFO
// and streams them into instruction memory at consecutive addresses.
module inst_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       FINISH,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [3:0] OP,
  input  logic [1:0] FN,
  input  logic [1:0] RD,
  output logic       IMEM_W_EN,
  output logic [7:0] IMEM_ADD,
  output logic [7:0] IMEM_DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ILLEGAL,
  output logic       OVF,
  output logic [8:0] COUNT
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

  state_t           state;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [8:0]       count;
  logic             illegal_q;
  logic             ovf_q;
  logic             vld_p1;
  logic [7:0]       add_p1;
  logic [7:0]       data_p1;

  logic [9:0]       pending;
  logic             fifo_empty;
  logic             fifo_full;
  logic             room;
  logic             busy_st;
  logic [7:0]       enc_byte_p0;
  logic             illegal_p0;
  logic             hs_p0;
  logic             vld_p0;
  logic             deq_p0;
  logic             ovf_hit;
  logic             load_go;

  function automatic logic [8:0] sat_inc_count(input logic [8:0] v);
    return (v >= 9'd256) ? 9'd256 : v + 9'd1;
  endfunction

  function automatic logic [OCC_W-1:0] next_occ(input logic [OCC_W-1:0] o,
                                                input logic inc, input logic dec);
    logic [OCC_W-1:0] r;
    r = o;
    if (inc && !dec) r = o + OCC_W'(1);
    if (dec && !inc) r = o - OCC_W'(1);
    return r;
  endfunction

  // Stage p0: handshake, encode, legality and capacity decisions
  assign pending     = {1'b0, count} + 10'(occ);
  assign fifo_empty  = (occ == '0);
  assign fifo_full   = (occ == OCC_FULL);
  assign room        = (pending < 10'd256);
  assign busy_st     = (state == ST_LOAD) || (state == ST_DRAIN);
  assign IN_READY    = (state == ST_LOAD) && !fifo_full && room;
  assign enc_byte_p0 = {OP, FN, RD};
  assign illegal_p0  = (OP == 4'h9) && (FN == 2'b11);
  assign hs_p0       = IN_VALID && IN_READY;
  assign vld_p0      = hs_p0 && !illegal_p0;
  assign deq_p0      = busy_st && !fifo_empty;
  // Overflow only when the 256-entry cap, not a momentarily full FIFO, blocks the request
  assign ovf_hit     = (state == ST_LOAD) && IN_VALID && !fifo_full && !room;
  assign load_go     = START && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge CLK) begin
    if (vld_p0) fifo_mem[wr_ptr] <= enc_byte_p0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      count     <= '0;
      illegal_q <= 1'b0;
      ovf_q     <= 1'b0;
      vld_p1    <= 1'b0;
      add_p1    <= '0;
      data_p1   <= '0;
    end else begin
      // Stage p1: registered instruction-memory write port
      vld_p1 <= deq_p0;
      if (deq_p0) begin
        add_p1  <= count[7:0];
        data_p1 <= fifo_mem[rd_ptr];
      end
      if (load_go) begin
        state     <= ST_LOAD;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        occ       <= '0;
        count     <= '0;
        illegal_q <= 1'b0;
        ovf_q     <= 1'b0;
      end else begin
        if (vld_p0) wr_ptr <= wr_ptr + PTR_W'(1);
        if (deq_p0) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          count  <= sat_inc_count(count);
        end
        occ <= next_occ(occ, vld_p0, deq_p0);
        if (hs_p0 && illegal_p0) illegal_q <= 1'b1;
        if (ovf_hit) ovf_q <= 1'b1;
        case (state)
          ST_LOAD:  if (FINISH) state <= ST_DRAIN;
          ST_DRAIN: if (fifo_empty && !vld_p1) state <= ST_DONE;
          default:  ;
        endcase
      end
    end
  end

  assign IMEM_W_EN = vld_p1;
  assign IMEM_ADD  = add_p1;
  assign IMEM_DATA = data_p1;
  assign BUSY      = busy_st;
  assign DONE      = (state == ST_DONE);
  assign ILLEGAL   = illegal_q;
  assign OVF       = ovf_q;
  assign COUNT     = count;
endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: vector table plus scoreboard of expected
// (address, byte) writes, with hand-written sequences for overflow and reset.
module tb_inst_encoder;
  logic       CLK = 1'b0;
  logic       RST_N, START, FINISH, IN_VALID;
  logic       IN_READY;
  logic [3:0] OP;
  logic [1:0] FN, RD;
  logic       IMEM_W_EN;
  logic [7:0] IMEM_ADD, IMEM_DATA;
  logic       BUSY, DONE, ILLEGAL, OVF;
  logic [8:0] COUNT;

  inst_encoder #(.FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .FINISH(FINISH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OP(OP), .FN(FN), .RD(RD),
    .IMEM_W_EN(IMEM_W_EN), .IMEM_ADD(IMEM_ADD), .IMEM_DATA(IMEM_DATA),
    .BUSY(BUSY), .DONE(DONE), .ILLEGAL(ILLEGAL), .OVF(OVF), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb [$];
  int          exp_addr = 0;

  typedef struct {
    logic [7:0] b;
    logic       legal;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest outstanding expected byte
  always @(negedge CLK) begin
    if (IMEM_W_EN === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 IMEM_ADD, IMEM_DATA);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        chk("wr_addr", 32'(IMEM_ADD), 32'(e[15:8]));
        chk("wr_data", 32'(IMEM_DATA), 32'(e[7:0]));
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] b, input logic exp_rdy,
                     input logic legal, input logic st, input logic fin);
    logic [7:0] a;
    IN_VALID = v;
    {OP, FN, RD} = b;
    START = st;
    FINISH = fin;
    #3;
    if (v) chk("in_ready", 32'(IN_READY), 32'(exp_rdy));
    if (v && exp_rdy && legal) begin
      a = exp_addr[7:0];
      sb.push_back({a, b});
      exp_addr++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_load();
    exp_addr = 0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("busy_after_start", 32'(BUSY), 32'd1);
  endtask

  task automatic finish_and_wait(input string name);
    int n;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (DONE !== 1'b1 && n < 600) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk(name, 32'(DONE), 32'd1);
    chk("busy_in_done", 32'(BUSY), 32'd0);
  endtask

  task automatic chk_reset();
    chk("rst_w_en",    32'(IMEM_W_EN), 32'd0);
    chk("rst_add",     32'(IMEM_ADD),  32'd0);
    chk("rst_data",    32'(IMEM_DATA), 32'd0);
    chk("rst_ready",   32'(IN_READY),  32'd0);
    chk("rst_busy",    32'(BUSY),      32'd0);
    chk("rst_done",    32'(DONE),      32'd0);
    chk("rst_illegal", 32'(ILLEGAL),   32'd0);
    chk("rst_ovf",     32'(OVF),       32'd0);
    chk("rst_count",   32'(COUNT),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    logic [7:0] b;
    RST_N = 1'b0; START = 1'b0; FINISH = 1'b0; IN_VALID = 1'b0;
    OP = '0; FN = '0; RD = '0;
    vecs = '{'{8'h9C, 1'b0}, '{8'h8D, 1'b1}, '{8'h9F, 1'b0}, '{8'h9B, 1'b1},
             '{8'h00, 1'b1}, '{8'hFF, 1'b1}, '{8'hA0, 1'b1}, '{8'h56, 1'b1}};

    repeat (2) @(posedge CLK);
    #1;
    chk_reset();
    RST_N = 1'b1;

    // FINISH in IDLE must not leave IDLE
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_finish_busy", 32'(BUSY), 32'd0);
    chk("idle_finish_done", 32'(DONE), 32'd0);

    // Single instruction: 0x3/01/10 -> 0x36 at address 0, two cycles after handshake
    start_load();
    cyc(1'b1, 8'h36, 1'b1, 1'b1, 1'b0, 1'b0);
    IN_VALID = 1'b0; FINISH = 1'b1;
    #3;
    chk("lat_cycle1_w_en", 32'(IMEM_W_EN), 32'd0);
    @(posedge CLK);
    #1;
    FINISH = 1'b0;
    #3;
    chk("lat_cycle2_w_en", 32'(IMEM_W_EN), 32'd1);
    chk("lat_cycle2_add",  32'(IMEM_ADD),  32'h00);
    chk("lat_cycle2_data", 32'(IMEM_DATA), 32'h36);
    @(posedge CLK);
    #1;
    finish_and_wait("single_done");
    chk("single_count", 32'(COUNT), 32'd1);
    chk("single_sb_empty", 32'(sb.size()), 32'd0);

    // Table of vectors with IN_VALID held; illegal ones are dropped
    start_load();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, vecs[i].b, 1'b1, vecs[i].legal, 1'b0, 1'b0);
      if (!vecs[i].legal) chk("illegal_sticky", 32'(ILLEGAL), 32'd1);
    end
    finish_and_wait("table_done");
    chk("table_count", 32'(COUNT), 32'd6);
    chk("table_illegal", 32'(ILLEGAL), 32'd1);
    chk("table_ovf", 32'(OVF), 32'd0);
    chk("table_sb_empty", 32'(sb.size()), 32'd0);

    // START from DONE clears the sticky flags and the count
    start_load();
    chk("restart_illegal", 32'(ILLEGAL), 32'd0);
    chk("restart_count", 32'(COUNT), 32'd0);

    // 258 back-to-back requests: 256 accepted, then overflow
    acc = 0;
    for (int i = 0; i < 258; i++) begin
      b = 8'(i);
      if (b[7:2] == 6'b100111) b = 8'h55;
      if (i == 256) chk("ovf_before_257th", 32'(OVF), 32'd0);
      cyc(1'b1, b, (acc < 256), 1'b1, 1'b0, 1'b0);
      if (acc < 256) acc++;
    end
    chk("ovf_set", 32'(OVF), 32'd1);
    finish_and_wait("stream_done");
    chk("stream_count", 32'(COUNT), 32'd256);
    chk("stream_last_add", 32'(IMEM_ADD), 32'hFF);
    chk("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Ten consecutive handshakes give ten consecutive writes; mid-load START ignored
    start_load();
    for (int k = 0; k < 13; k++) begin
      IN_VALID = (k < 10);
      b = 8'h40 + 8'(k);
      {OP, FN, RD} = b;
      START = (k == 5);
      #3;
      if (k < 10) begin
        chk("burst_ready", 32'(IN_READY), 32'd1);
        sb.push_back({exp_addr[7:0], b});
        exp_addr++;
      end
      chk("burst_w_en", 32'(IMEM_W_EN), 32'((k >= 2) && (k < 12)));
      @(posedge CLK);
      #1;
    end
    START = 1'b0;
    finish_and_wait("burst_done");
    chk("burst_count", 32'(COUNT), 32'd10);

    // Reset mid-load with a byte still queued; reset dominates START/FINISH
    start_load();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h11 * 8'(i + 1), 1'b1, 1'b1, 1'b0, 1'b0);
    RST_N = 1'b0; IN_VALID = 1'b0; START = 1'b1; FINISH = 1'b1;
    @(posedge CLK);
    #1;
    RST_N = 1'b1; START = 1'b0; FINISH = 1'b0;
    chk_reset();
    chk("rst_abandoned_bytes", 32'(sb.size()), 32'd1);
    sb.delete();
    idle(4);
    chk("post_rst_busy", 32'(BUSY), 32'd0);
    chk("post_rst_count", 32'(COUNT), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
